pipeline_hazard_controller: RTL and testbench



---
 rtl/pipeline_hazard_controller_if.sv | 35 +++
 rtl/pipeline_hazard_controller.sv | 97 +++++++++
 tb/tb_pipeline_hazard_controller.sv | 199 +++++++++++++++++++
 3 files changed

// File: rtl/pipeline_hazard_controller_if.sv
// Hazard-control bus between the pipeline datapath and the hazard controller.
interface pipeline_hazard_controller_if;
    logic [4:0]  ifIdRs;
    logic [4:0]  ifIdRt;
    logic        ifIdUsesRt;
    logic        ifIdMul;
    logic [4:0]  idExRt;
    logic        idExMemRead;
    logic        branchTaken;
    logic        stallClear;
    logic        pcWrite;
    logic        ifIdWrite;
    logic        idExWrite;
    logic        ifIdFlush;
    logic        idExFlush;
    logic        exMemFlush;
    logic        mulBusy;
    logic [15:0] stallCycles;

    // Controller side: consumes pipeline status, drives enables and flushes.
    modport master (
        input  ifIdRs, ifIdRt, ifIdUsesRt, ifIdMul, idExRt, idExMemRead,
               branchTaken, stallClear,
        output pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush,
               exMemFlush, mulBusy, stallCycles
    );

    // Datapath side: provides pipeline status, obeys enables and flushes.
    modport slave (
        output ifIdRs, ifIdRt, ifIdUsesRt, ifIdMul, idExRt, idExMemRead,
               branchTaken, stallClear,
        input  pcWrite, ifIdWrite, idExWrite, ifIdFlush, idExFlush,
               exMemFlush, mulBusy, stallCycles
    );
endinterface

// File: rtl/pipeline_hazard_controller.sv
// Five-stage pipeline hazard controller: load-use bubbles, multi-cycle
// multiply holds, taken-branch squashes and a saturating stall counter.
module pipeline_hazard_controller #(
    parameter int unsigned MUL_CYCLES = 4,
    parameter int unsigned CNT_WIDTH  = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    pipeline_hazard_controller_if.master  bus
);
    localparam int unsigned STALL_W = 16;

    typedef enum logic [0:0] {RUN, MUL_WAIT} state_t;

    state_t               state_q, state_d;
    logic [CNT_WIDTH-1:0] mul_cnt_q, mul_cnt_d;
    logic [STALL_W-1:0]   stall_cycles_q, stall_cycles_d;

    logic load_use;
    logic hold;
    logic pc_write, if_id_write, id_ex_write;
    logic if_id_flush, id_ex_flush, ex_mem_flush, mul_busy;

    // Hazard detection from the current IF/ID and ID/EX contents.
    always_comb begin
        load_use = bus.idExMemRead && (bus.idExRt != 5'd0) &&
                   ((bus.idExRt == bus.ifIdRs) ||
                    (bus.ifIdUsesRt && (bus.idExRt == bus.ifIdRt)));
        hold     = (state_q == MUL_WAIT) && (mul_cnt_q != '0);
    end

    // Next-state and control outputs: hold > branch > load-use > multiply > normal.
    always_comb begin
        state_d        = state_q;
        mul_cnt_d      = mul_cnt_q;
        pc_write       = 1'b1;
        if_id_write    = 1'b1;
        id_ex_write    = 1'b1;
        if_id_flush    = 1'b0;
        id_ex_flush    = 1'b0;
        ex_mem_flush   = 1'b0;
        mul_busy       = 1'b0;
        stall_cycles_d = stall_cycles_q;

        if (hold) begin
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_write  = 1'b0;
            ex_mem_flush = 1'b1;
            mul_busy     = 1'b1;
            mul_cnt_d    = mul_cnt_q - CNT_WIDTH'(1);
        end else if (bus.branchTaken) begin
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
            state_d     = RUN;
            mul_cnt_d   = '0;
        end else if (load_use) begin
            pc_write    = 1'b0;
            if_id_write = 1'b0;
            id_ex_flush = 1'b1;
        end else if (bus.ifIdMul) begin
            state_d   = MUL_WAIT;
            mul_cnt_d = CNT_WIDTH'(MUL_CYCLES - 1);
        end else begin
            state_d   = RUN;
            mul_cnt_d = '0;
        end

        if (bus.stallClear) begin
            stall_cycles_d = '0;
        end else if (!pc_write && (stall_cycles_q != {STALL_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + STALL_W'(1);
        end
    end

    // State, multiply countdown and stall counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= RUN;
            mul_cnt_q      <= '0;
            stall_cycles_q <= '0;
        end else begin
            state_q        <= state_d;
            mul_cnt_q      <= mul_cnt_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign bus.pcWrite     = pc_write;
    assign bus.ifIdWrite   = if_id_write;
    assign bus.idExWrite   = id_ex_write;
    assign bus.ifIdFlush   = if_id_flush;
    assign bus.idExFlush   = id_ex_flush;
    assign bus.exMemFlush  = ex_mem_flush;
    assign bus.mulBusy     = mul_busy;
    assign bus.stallCycles = stall_cycles_q;
endmodule

// File: tb/tb_pipeline_hazard_controller.sv
// Directed and randomized bench for pipeline_hazard_controller against a
// cycle-level behavioural model of the hazard rules.
module tb_pipeline_hazard_controller;
    localparam int unsigned MUL = 4;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    // Model state: remaining multiply hold cycles and stall count.
    int m_rem   = 0;
    int m_stall = 0;

    pipeline_hazard_controller_if bus ();

    pipeline_hazard_controller #(.MUL_CYCLES(MUL), .CNT_WIDTH(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_in(input logic [4:0] rs, input logic [4:0] rt, input logic uses_rt,
                          input logic mul, input logic [4:0] ex_rt, input logic mem_rd,
                          input logic br, input logic clr, input logic r);
        bus.ifIdRs      = rs;
        bus.ifIdRt      = rt;
        bus.ifIdUsesRt  = uses_rt;
        bus.ifIdMul     = mul;
        bus.idExRt      = ex_rt;
        bus.idExMemRead = mem_rd;
        bus.branchTaken = br;
        bus.stallClear  = clr;
        rst             = r;
    endtask

    task automatic idle(input logic r);
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, r);
    endtask

    // Check one cycle's outputs against the model, then clock and advance the model.
    task automatic tick(input bit do_chk);
        bit hazard, stall_pc;
        logic [6:0] e;   // pcW, ifIdW, idExW, ifIdF, idExF, exMemF, busy
        int n_rem, n_stall;
        #1;
        hazard = 1'b0;
        if (bus.idExMemRead && bus.idExRt != 0) begin
            if (bus.idExRt == bus.ifIdRs) hazard = 1'b1;
            if (bus.ifIdUsesRt && bus.idExRt == bus.ifIdRt) hazard = 1'b1;
        end
        n_rem = 0;
        if (m_rem > 0) begin
            e = 7'b000_0011;
            n_rem = m_rem - 1;
        end else if (bus.branchTaken) begin
            e = 7'b111_1100;
        end else if (hazard) begin
            e = 7'b001_0100;
        end else begin
            e = 7'b111_0000;
            if (bus.ifIdMul) n_rem = MUL - 1;
        end
        stall_pc = (e[6] == 1'b0);
        if (bus.stallClear)   n_stall = 0;
        else if (stall_pc)    n_stall = (m_stall + 1 > 65535) ? 65535 : m_stall + 1;
        else                  n_stall = m_stall;
        if (rst) begin
            n_rem   = 0;
            n_stall = 0;
        end
        if (do_chk) begin
            chk("pcWrite",     16'(bus.pcWrite),    16'(e[6]));
            chk("ifIdWrite",   16'(bus.ifIdWrite),  16'(e[5]));
            chk("idExWrite",   16'(bus.idExWrite),  16'(e[4]));
            chk("ifIdFlush",   16'(bus.ifIdFlush),  16'(e[3]));
            chk("idExFlush",   16'(bus.idExFlush),  16'(e[2]));
            chk("exMemFlush",  16'(bus.exMemFlush), 16'(e[1]));
            chk("mulBusy",     16'(bus.mulBusy),    16'(e[0]));
            chk("stallCycles", bus.stallCycles,     16'(m_stall));
        end
        @(posedge clk);
        #1;
        m_rem   = n_rem;
        m_stall = n_stall;
    endtask

    initial begin
        // Reset, then idle defaults.
        idle(1'b1);
        tick(1'b0);
        tick(1'b0);
        idle(1'b0);
        #1;
        chk("rst_stall", bus.stallCycles, 16'd0);
        chk("rst_pcw",   16'(bus.pcWrite), 16'd1);
        tick(1'b1);

        // Load-use on rs: one bubble, counted once.
        set_in(5'd5, 5'd1, 1'b0, 1'b0, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0);
        #1;
        chk("lu_pcw",  16'(bus.pcWrite),   16'd0);
        chk("lu_ifid", 16'(bus.ifIdWrite), 16'd0);
        chk("lu_idf",  16'(bus.idExFlush), 16'd1);
        tick(1'b1);
        idle(1'b0);
        tick(1'b1);
        chk("lu_count", bus.stallCycles, 16'd1);

        // Register zero and unused rt never stall.
        set_in(5'd0, 5'd3, 1'b1, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1);
        set_in(5'd2, 5'd7, 1'b0, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1);
        set_in(5'd2, 5'd7, 1'b1, 1'b0, 5'd7, 1'b1, 1'b0, 1'b0, 1'b0);
        tick(1'b1);

        // Single multiply: three holds then a full advance.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1);
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1);
        idle(1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1);
        chk("mul_count", bus.stallCycles, 16'd3);
        chk("mul_done",  16'(bus.mulBusy), 16'd0);
        tick(1'b1);

        // Branch beats load-use and multiply.
        set_in(5'd6, 5'd0, 1'b0, 1'b1, 5'd6, 1'b1, 1'b1, 1'b0, 1'b0);
        #1;
        chk("br_pcw", 16'(bus.pcWrite),   16'd1);
        chk("br_iff", 16'(bus.ifIdFlush), 16'd1);
        tick(1'b1);
        idle(1'b0);
        #1;
        chk("br_nomul", 16'(bus.mulBusy), 16'd0);
        tick(1'b1);

        // Back-to-back multiplies: 3 stalls, advance, 3 stalls.
        set_in(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(1'b1);
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) tick(1'b1);
        idle(1'b0);
        for (int i = 0; i < 4; i++) tick(1'b1);
        chk("b2b_count", bus.stallCycles, 16'd6);

        // Reset at the second hold cycle abandons the multiply.
        set_in(5'd0, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(1'b1);
        idle(1'b0);
        tick(1'b1);
        idle(1'b1);
        tick(1'b1);
        idle(1'b0);
        #1;
        chk("rstmul_busy",  16'(bus.mulBusy), 16'd0);
        chk("rstmul_stall", bus.stallCycles,  16'd0);
        for (int i = 0; i < 3; i++) tick(1'b1);

        // Randomized traffic with small register indices to provoke matches.
        for (int i = 0; i < 1500; i++) begin
            set_in(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0),
                   5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 39) == 0),
                   1'($urandom_range(0, 49) == 0));
            tick(1'b1);
        end

        // Saturation under a continuous load-use stall, then clear.
        set_in(5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 70000; i++) tick(1'b0);
        chk("sat_value", bus.stallCycles, 16'hFFFF);
        tick(1'b1);
        tick(1'b1);
        chk("sat_hold", bus.stallCycles, 16'hFFFF);
        set_in(5'd4, 5'd0, 1'b0, 1'b0, 5'd4, 1'b1, 1'b0, 1'b1, 1'b0);
        tick(1'b1);
        idle(1'b0);
        #1;
        chk("sat_clear", bus.stallCycles, 16'd0);
        tick(1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
